// File: rtl/uart_xmit_if.sv
// Strobe-side handshake and serial-line signals of the 8N1 UART transmitter.
// The controller drives the request and clear strobes; the transmitter drives the line and the flags.
interface uart_xmit_if;
  logic       trmt;
  logic [7:0] tx_data;
  logic       tx_done_clr;
  logic       TX;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output trmt, tx_data, tx_done_clr,
    input  TX, tx_busy, tx_done
  );

  modport slave (
    input  trmt, tx_data, tx_done_clr,
    output TX, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_xmit.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit, BAUD_DIV clocks per bit.
// TX comes straight from a flop so the line never glitches; tx_done is a sticky completion flag.
module uart_xmit #(
  parameter int BAUD_DIV = 2604
) (
  input logic        clk,
  input logic        rst_n,
  uart_xmit_if.slave bus
);

  typedef enum logic {IDLE, TRANSMIT} state_t;

  localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);

  state_t      state, state_nxt;
  logic [9:0]  sr, sr_nxt;
  logic [11:0] baud_cnt, baud_nxt;
  logic [3:0]  bit_cnt, bit_nxt;
  logic        done, done_nxt;
  logic        baud_tick;
  logic        accept;
  logic        frame_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sr       <= 10'h3FF;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      sr       <= sr_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      done     <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    accept    = 1'b0;
    frame_end = 1'b0;
    baud_tick = (baud_cnt == BAUD_LAST);

    case (state)
      IDLE: begin
        if (bus.trmt) begin
          accept    = 1'b1;
          sr_nxt    = {1'b1, bus.tx_data, 1'b0};
          baud_nxt  = '0;
          bit_nxt   = '0;
          state_nxt = TRANSMIT;
        end
      end
      TRANSMIT: begin
        if (baud_tick) begin
          baud_nxt = '0;
          sr_nxt   = {1'b1, sr[9:1]};
          bit_nxt  = bit_cnt + 4'd1;
          // Tenth shift has just pushed the stop bit out: line is back to idle-high.
          if (bit_cnt == 4'd9) begin
            frame_end = 1'b1;
            state_nxt = IDLE;
          end
        end else begin
          baud_nxt = baud_cnt + 12'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Clear and acceptance both win over the end-of-frame set.
    if (bus.tx_done_clr)
      done_nxt = 1'b0;
    else if (accept)
      done_nxt = 1'b0;
    else if (frame_end)
      done_nxt = 1'b1;
    else
      done_nxt = done;
  end

  assign bus.TX      = sr[0];
  assign bus.tx_busy = (state == TRANSMIT);
  assign bus.tx_done = done;

endmodule

// File: tb/tb_uart_xmit.sv
// Randomized scoreboard bench for uart_xmit: a cycle-level frame model predicts the pins,
// and a line deserializer pops expected bytes from a queue as each frame completes.
module tb_uart_xmit;
  localparam int B = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  uart_xmit_if bus();

  uart_xmit #(.BAUD_DIV(B)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;

  logic [7:0] sb[$];
  int         starts[$];

  // Reference model: a frame occupies 10*B edges starting at the accept edge k;
  // the line shows frame bit (e-k)/B after edge e, and is idle-high otherwise.
  int         cyc = 0;
  bit         m_act = 1'b0;
  int         m_k = 0;
  logic [9:0] m_frame = '1;
  logic       m_tx = 1'b1;
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  bit         m_acc, m_fin;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act  = 1'b0;
      m_tx   = 1'b1;
      m_busy = 1'b0;
      m_done = 1'b0;
      sb.delete();
    end else begin
      cyc++;
      m_acc = 1'b0;
      m_fin = 1'b0;
      if (m_act && cyc == m_k + 10 * B) begin
        m_act = 1'b0;
        m_fin = 1'b1;
      end else if (!m_act && bus.trmt === 1'b1) begin
        m_act   = 1'b1;
        m_k     = cyc;
        m_frame = {1'b1, bus.tx_data, 1'b0};
        m_acc   = 1'b1;
        sb.push_back(bus.tx_data);
      end
      if (bus.tx_done_clr === 1'b1) m_done = 1'b0;
      else if (m_acc)               m_done = 1'b0;
      else if (m_fin)               m_done = 1'b1;
      m_busy = m_act;
      m_tx   = m_act ? m_frame[(cyc - m_k) / B] : 1'b1;
    end
  end

  // Monitor: pin-level comparison each cycle, plus mid-bit deserialization of every frame.
  logic       prev_tx = 1'b1;
  bit         rx_act = 1'b0;
  int         rx_cnt = 0;
  logic [9:0] rx_bits = '0;
  logic [7:0] exp_byte;

  always @(negedge clk) begin
    if (n_miss < 30) begin
      n_vec++;
      if ({bus.TX, bus.tx_busy, bus.tx_done} !== {m_tx, m_busy, m_done}) begin
        n_miss++;
        $display("FAIL pins cyc=%0d TX/busy/done actual=%b%b%b required=%b%b%b",
                 cyc, bus.TX, bus.tx_busy, bus.tx_done, m_tx, m_busy, m_done);
      end
    end
    if (!rst_n) begin
      rx_act  = 1'b0;
      prev_tx = 1'b1;
    end else begin
      if (!rx_act) begin
        if (prev_tx === 1'b1 && bus.TX === 1'b0) begin
          rx_act = 1'b1;
          rx_cnt = 0;
          starts.push_back(cyc);
        end
      end else begin
        rx_cnt++;
      end
      if (rx_act && (rx_cnt % B) == B / 2) begin
        rx_bits[rx_cnt / B] = bus.TX;
        if (rx_cnt / B == 9) begin
          rx_act = 1'b0;
          n_vec++;
          if (sb.size() == 0) begin
            n_miss++;
            $display("FAIL frame cyc=%0d actual=%b required=no frame", cyc, rx_bits);
          end else begin
            exp_byte = sb.pop_front();
            if (rx_bits !== {1'b1, exp_byte, 1'b0}) begin
              n_miss++;
              $display("FAIL frame cyc=%0d actual=%b required=%b", cyc, rx_bits, {1'b1, exp_byte, 1'b0});
            end
          end
        end
      end
      prev_tx = bus.TX;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic send(input logic [7:0] d);
    bus.tx_data = d;
    bus.trmt    = 1'b1;
    tick();
    bus.trmt    = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    bus.trmt        = 1'b0;
    bus.tx_data     = 8'h00;
    bus.tx_done_clr = 1'b0;
    rst_n           = 1'b0;
    repeat (3) tick();
    check("reset_tx", bus.TX, 1);
    check("reset_busy", bus.tx_busy, 0);
    check("reset_done", bus.tx_done, 0);
    rst_n = 1'b1;
    tick();

    send(8'hA5);
    check("a5_start_bit", bus.TX, 0);
    check("a5_busy", bus.tx_busy, 1);
    repeat (10 * B - 1) tick();
    check("a5_done_early", bus.tx_done, 0);
    check("a5_busy_late", bus.tx_busy, 1);
    tick();
    check("a5_done", bus.tx_done, 1);
    check("a5_busy_end", bus.tx_busy, 0);
    check("a5_idle_tx", bus.TX, 1);

    bus.tx_done_clr = 1'b1;
    tick();
    bus.tx_done_clr = 1'b0;
    check("clr_done", bus.tx_done, 0);

    send(8'h3C);
    repeat (39) tick();
    bus.tx_data = 8'hFF;
    bus.trmt    = 1'b1;
    tick();
    bus.trmt    = 1'b0;
    bus.tx_data = 8'h00;
    repeat (10 * B - 40) tick();
    check("3c_done", bus.tx_done, 1);
    repeat (5) tick();
    check("3c_no_second", bus.tx_busy, 0);

    send(8'($urandom));
    repeat (10 * B - 1) tick();
    bus.tx_done_clr = 1'b1;
    tick();
    bus.tx_done_clr = 1'b0;
    check("clr_beats_set", bus.tx_done, 0);
    check("clr_frame_over", bus.tx_busy, 0);

    send(8'($urandom));
    repeat (10 * B) tick();
    check("done_before_accept", bus.tx_done, 1);
    send(8'($urandom));
    check("accept_clears_done", bus.tx_done, 0);
    repeat (10 * B) tick();

    repeat (3) tick();
    starts.delete();
    bus.tx_data = 8'h00;
    bus.trmt    = 1'b1;
    tick();
    bus.tx_data = 8'h80;
    repeat (10 * B + 1) tick();
    bus.trmt = 1'b0;
    repeat (10 * B) tick();
    check("b2b_frames", starts.size(), 2);
    d = (starts.size() >= 2) ? starts[1] - starts[0] : -1;
    check("b2b_period", d, 10 * B + 1);

    for (int f = 0; f < 8; f++) begin
      repeat ($urandom_range(0, 20)) tick();
      send(8'($urandom));
      repeat (10 * B - 1) begin
        bus.trmt        = 1'($urandom_range(0, 1));
        bus.tx_data     = 8'($urandom);
        bus.tx_done_clr = ($urandom_range(0, 15) == 0);
        tick();
      end
      bus.trmt        = 1'b0;
      bus.tx_done_clr = 1'b0;
      tick();
    end
    repeat (3) tick();

    send(8'hE7);
    repeat (4 * B + B / 2) tick();
    #2 rst_n = 1'b0;
    #1;
    check("abort_tx", bus.TX, 1);
    check("abort_busy", bus.tx_busy, 0);
    check("abort_done", bus.tx_done, 0);
    repeat (100) tick();
    check("abort_hold_tx", bus.TX, 1);
    check("abort_hold_done", bus.tx_done, 0);
    rst_n = 1'b1;
    tick();
    send(8'h5A);
    repeat (10 * B) tick();
    check("recover_done", bus.tx_done, 1);
    repeat (3) tick();

    check("queue_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/uart_xmit.md
# uart_xmit

8N1 UART transmitter serializing one byte per request onto a single TX line: start bit (0), 8 data bits LSB first, stop bit (1). It is the transmit-side counterpart to the team's 8N1 UART receiver and shares its bit period (2604 clk cycles per bit) so the two can be looped back. It sits between a byte-producing controller (trmt/tx_data strobe interface) and the serial pin, with a sticky done flag mirroring the receiver's ready/clear handshake.

## Interface
- BAUD_DIV, 2604: clk cycles per serial bit; legal range 2..4096 (baud counter is 12 bits).
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- trmt  input  1  start request; sampled each posedge; honoured only in IDLE.
- tx_data  input  8  byte to send; captured only on the posedge where trmt is accepted.
- tx_done_clr  input  1  synchronous clear of tx_done.
- TX  output  1  serial line; idles high.
- tx_busy  output  1  high while a frame is in progress (state TRANSMIT).
- tx_done  output  1  sticky flag: last frame fully sent, including stop bit.

## Operation
- Registers: 10-bit shift register sr, 12-bit baud counter baud_cnt, 4-bit bit counter bit_cnt, 1-bit state (IDLE, TRANSMIT), tx_done flop.
- TX is driven directly from sr[0] (glitch-free, registered).
- Reset values: sr = 10'h3FF (TX = 1), baud_cnt = 0, bit_cnt = 0, state = IDLE, tx_busy = 0, tx_done = 0.
- IDLE: if trmt = 1 -> sr <= {1'b1, tx_data, 1'b0}, baud_cnt <= 0, bit_cnt <= 0, state <= TRANSMIT. Otherwise hold; sr stays all-ones.
- TRANSMIT: baud_cnt increments each cycle. When baud_cnt == BAUD_DIV-1: baud_cnt <= 0, sr <= {1'b1, sr[9:1]} (fill with ones), bit_cnt <= bit_cnt + 1. If that shift is the 10th (bit_cnt == 9 before increment): state <= IDLE, tx_done set.
- trmt while TRANSMIT is ignored; tx_data changes after acceptance have no effect.
- tx_busy = (state == TRANSMIT).
- tx_done priority, highest first: reset -> 0; tx_done_clr -> 0; trmt accepted in IDLE -> 0; end-of-frame -> 1; else hold. Clear beats set on the same edge.
- Reset mid-frame: TX returns high immediately (async), frame aborted, no tx_done.

## Timing
- Let trmt be sampled high in IDLE at posedge k.
- TX falls (start bit) after posedge k; latency 1 edge from trmt.
- Data bit n (n = 0..7) on TX from edge k + (n+1)*BAUD_DIV to k + (n+2)*BAUD_DIV.
- Stop bit from edge k + 9*BAUD_DIV; every bit exactly BAUD_DIV cycles.
- At edge k + 10*BAUD_DIV: state = IDLE, tx_busy = 0, tx_done = 1, TX = 1.
- trmt at edge k + 10*BAUD_DIV is still seen in TRANSMIT and ignored; earliest next accept is edge k + 10*BAUD_DIV + 1. Minimum frame-to-frame period 10*BAUD_DIV + 1 cycles (≥ 1 idle-high cycle between stop and next start).
- tx_busy rises after edge k, falls after edge k + 10*BAUD_DIV.

## Test plan
- Reset: assert rst_n = 0 mid-simulation -> TX = 1, tx_busy = 0, tx_done = 0 immediately; all hold for 100 cycles with trmt = 0.
- Single byte, BAUD_DIV = 16: trmt pulse with tx_data = 8'hA5 -> TX sequence 0,1,0,1,0,0,1,0,1,1 each held 16 cycles; tx_done = 1 and tx_busy = 0 exactly 160 edges after trmt.
- Ignore-while-busy: trmt with 8'h3C, then trmt with 8'hFF at cycle 40 and tx_data changed to 8'h00 -> frame still carries 8'h3C; only one tx_done.
- Flag handshake: after done, tx_done_clr pulse -> tx_done 0 next edge; tx_done_clr coincident with end-of-frame -> tx_done stays 0; new trmt clears a set tx_done on acceptance edge.
- Back-to-back, BAUD_DIV = 16: trmt held high continuously with 8'h00 then 8'h80 -> frames start 161 cycles apart, one idle-high cycle between stop and start.
- Loopback at default BAUD_DIV = 2604: TX into the team's 8N1 receiver, send 8'h55, 8'hC3, 8'h01 -> receiver reports identical bytes; abort test: rst_n pulse at bit 4 -> TX high, no tx_done.
